// File: rtl/vwu_pkg.sv
// Shared constants and types for the core data memory arbiter.
package vwu_pkg;

    localparam logic [31:0] DataMemBaseAddr = 32'h0002_0000;
    localparam int unsigned DataMemNumWords = 128;

    typedef logic [$clog2(DataMemNumWords)-1:0] dmem_sram_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        INFLIGHT,
        HOLD
    } dmem_rsp_state_e;

endpackage

// File: rtl/vwu_dmem_rsp_slot.sv
// Per-port response slot: tracks the single outstanding access of one requester and
// parks the response in a hold register while the requester applies backpressure.
module vwu_dmem_rsp_slot
    import vwu_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 grant,
    input  logic                 grant_write,
    input  logic                 grant_error,
    input  logic                 rsp_ready,
    input  logic [DataWidth-1:0] sram_rdata,
    output logic                 blocked,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_error
);

    dmem_rsp_state_e      state;
    dmem_rsp_state_e      state_next;
    logic                 pend_zero;
    logic                 pend_error;
    logic                 hold_error;
    logic [DataWidth-1:0] hold_rdata;
    logic [DataWidth-1:0] live_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (grant) state_next = INFLIGHT;
            INFLIGHT: begin
                if (!rsp_ready) begin
                    state_next = HOLD;
                end else if (!grant) begin
                    state_next = IDLE;
                end
            end
            HOLD:     if (rsp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Writes and rejected accesses answer with zero data instead of the SRAM output.
    always_comb begin
        live_rdata = pend_zero ? '0 : sram_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_zero  <= 1'b0;
            pend_error <= 1'b0;
            hold_error <= 1'b0;
            hold_rdata <= '0;
        end else begin
            if (grant) begin
                pend_zero  <= grant_write || grant_error;
                pend_error <= grant_error;
            end
            if (state == INFLIGHT && !rsp_ready) begin
                hold_rdata <= live_rdata;
                hold_error <= pend_error;
            end
        end
    end

    // Outputs are forced low while reset is asserted so nothing is presented mid-reset.
    always_comb begin
        blocked   = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_error = 1'b0;
        if (!rst) begin
            case (state)
                INFLIGHT: begin
                    blocked   = !rsp_ready;
                    rsp_valid = 1'b1;
                    rsp_rdata = live_rdata;
                    rsp_error = pend_error;
                end
                HOLD: begin
                    blocked   = 1'b1;
                    rsp_valid = 1'b1;
                    rsp_rdata = hold_rdata;
                    rsp_error = hold_error;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vwu_dmem_arbiter.sv
// Round-robin arbiter sharing the core data memory SRAM between the LSU (port 0) and the
// cluster bus (port 1). Define VWU_DMEM_ARB_ADDR_CHECK_EN to reject out-of-window requests.
module vwu_dmem_arbiter
    import vwu_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumWords      = DataMemNumWords,
    parameter logic [AddrWidth-1:0] BaseAddr      = AddrWidth'(DataMemBaseAddr),
    parameter int unsigned          SramAddrWidth = $clog2(NumWords)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [1:0]                        req_valid_i,
    output logic [1:0]                        req_ready_o,
    input  logic [1:0][AddrWidth-1:0]         req_addr_i,
    input  logic [1:0]                        req_write_i,
    input  logic [1:0][DataWidth-1:0]         req_wdata_i,
    input  logic [1:0][DataWidth/8-1:0]       req_strb_i,
    output logic [1:0]                        rsp_valid_o,
    input  logic [1:0]                        rsp_ready_i,
    output logic [1:0][DataWidth-1:0]         rsp_rdata_o,
    output logic [1:0]                        rsp_error_o,
    output logic                              sram_req_o,
    output logic                              sram_we_o,
    output logic [SramAddrWidth-1:0]          sram_addr_o,
    output logic [DataWidth-1:0]              sram_wdata_o,
    output logic [DataWidth/8-1:0]            sram_be_o,
    input  logic [DataWidth-1:0]              sram_rdata_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned ByteOffW  = $clog2(StrbWidth);
    localparam logic [AddrWidth-1:0] WindowBytes = AddrWidth'(NumWords * StrbWidth);

    logic [1:0]           blocked;
    logic [1:0]           eligible;
    logic [1:0]           grant;
    logic                 rr_ptr;
    logic                 winner;
    logic [AddrWidth-1:0] win_addr;
    logic [AddrWidth-1:0] win_offset;
    logic                 win_error;
    logic                 access;
    logic                 unused_offset_bits;

    // rr_ptr holds the last tie winner; the other port takes the next tie.
    always_comb begin
        eligible = rst_i ? 2'b00 : (req_valid_i & ~blocked);
        case (eligible)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~rr_ptr;
            default: winner = 1'b0;
        endcase
        grant = '0;
        if (eligible != 2'b00) begin
            grant[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= 1'b1;
        end else if (eligible == 2'b11) begin
            rr_ptr <= winner;
        end
    end

    assign req_ready_o = grant;

    always_comb begin
        win_addr   = req_addr_i[winner];
        win_offset = win_addr - BaseAddr;
    end

`ifdef VWU_DMEM_ARB_ADDR_CHECK_EN
    assign win_error = (win_addr < BaseAddr) || (win_offset >= WindowBytes);
`else
    assign win_error = 1'b0;
`endif

    assign access = (grant != 2'b00) && !win_error;

    // Address bits above the window are dropped, so out-of-window requests alias.
    assign unused_offset_bits = ^{win_offset[AddrWidth-1:SramAddrWidth+ByteOffW],
                                  win_offset[ByteOffW-1:0]};

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (access) begin
            sram_req_o   = 1'b1;
            sram_we_o    = req_write_i[winner];
            sram_addr_o  = win_offset[SramAddrWidth+ByteOffW-1:ByteOffW];
            sram_wdata_o = req_wdata_i[winner];
            sram_be_o    = req_strb_i[winner];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_slot
        vwu_dmem_rsp_slot #(
            .DataWidth(DataWidth)
        ) u_slot (
            .clk        (clk_i),
            .rst        (rst_i),
            .grant      (grant[p]),
            .grant_write(req_write_i[p]),
            .grant_error(win_error),
            .rsp_ready  (rsp_ready_i[p]),
            .sram_rdata (sram_rdata_i),
            .blocked    (blocked[p]),
            .rsp_valid  (rsp_valid_o[p]),
            .rsp_rdata  (rsp_rdata_o[p]),
            .rsp_error  (rsp_error_o[p])
        );
    end

endmodule

// File: tb/tb_vwu_dmem_arbiter.sv
// Self-checking bench for vwu_dmem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of grants, responses and memory contents.
module tb_vwu_dmem_arbiter;
    import vwu_pkg::*;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][31:0]      req_addr;
    logic [1:0]            req_write;
    logic [1:0][31:0]      req_wdata;
    logic [1:0][3:0]       req_strb;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [1:0][31:0]      rsp_rdata;
    logic [1:0]            rsp_error;
    logic                  sram_req;
    logic                  sram_we;
    dmem_sram_addr_t       sram_addr;
    logic [31:0]           sram_wdata;
    logic [3:0]            sram_be;
    logic [31:0]           sram_rdata;

    vwu_dmem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .sram_req_o  (sram_req),
        .sram_we_o   (sram_we),
        .sram_addr_o (sram_addr),
        .sram_wdata_o(sram_wdata),
        .sram_be_o   (sram_be),
        .sram_rdata_i(sram_rdata)
    );

    // External SRAM: byte-enabled write, one-cycle read latency.
    logic        seed_mem;
    logic [31:0] mem_seed;
    logic [31:0] sram_mem [128];
    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 128; i++) sram_mem[i] <= mem_seed ^ (32'(i) * 32'h9E37_79B9);
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model state.
    logic [31:0] mmem [128];
    bit          outst [2];
    bit          fresh [2];
    logic [31:0] exp_d [2];
    bit          exp_e [2];
    int          ptr;

    int n_checks;
    int n_fail;

    logic [1:0]       obs_gnt;
    logic [1:0]       obs_valid;
    logic [1:0][31:0] obs_rdata;
    logic [1:0]       obs_err;
    logic             obs_sram_req;
    logic             obs_sram_we;
    dmem_sram_addr_t  obs_sram_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    task automatic issue(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req_valid[p] = 1'b1;
        req_write[p] = w;
        req_addr[p]  = a;
        req_wdata[p] = d;
        req_strb[p]  = s;
    endtask

    // One clock cycle: predict, compare, advance the model, then clock the DUT.
    task automatic do_cycle();
        logic [1:0]  elig;
        logic [1:0]  gnt;
        int          w;
        logic [31:0] off;
        logic [31:0] idx;
        logic        err;
        logic        acc;
        #2;
        for (int p = 0; p < 2; p++)
            elig[p] = req_valid[p] && !(outst[p] && (!fresh[p] || !rsp_ready[p]));
        w = -1;
        if (elig == 2'b11) w = (ptr == 1) ? 0 : 1;
        else if (elig[0])  w = 0;
        else if (elig[1])  w = 1;
        gnt = 2'b00;
        if (w >= 0) gnt[w] = 1'b1;
        err = 1'b0;
        idx = '0;
        if (w >= 0) begin
            off = req_addr[w] - BASE;
            idx = (off >> 2) % 128;
`ifdef VWU_DMEM_ARB_ADDR_CHECK_EN
            err = (req_addr[w] < BASE) || (req_addr[w] >= BASE + 32'd512);
`endif
        end
        acc = (w >= 0) && !err;

        obs_gnt       = req_ready;
        obs_valid     = rsp_valid;
        obs_rdata     = rsp_rdata;
        obs_err       = rsp_error;
        obs_sram_req  = sram_req;
        obs_sram_we   = sram_we;
        obs_sram_addr = sram_addr;

        check("req_ready", req_ready, gnt);
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rsp_valid%0d", p), rsp_valid[p], outst[p]);
            check($sformatf("rsp_rdata%0d", p), rsp_rdata[p], outst[p] ? exp_d[p] : 32'h0);
            check($sformatf("rsp_error%0d", p), rsp_error[p], outst[p] ? exp_e[p] : 1'b0);
        end
        check("sram_req", sram_req, acc);
        if (acc) begin
            check("sram_addr", sram_addr, idx);
            check("sram_we", sram_we, req_write[w]);
            if (req_write[w]) begin
                check("sram_wdata", sram_wdata, req_wdata[w]);
                check("sram_be", sram_be, req_strb[w]);
            end
        end

        for (int p = 0; p < 2; p++) begin
            if (outst[p] && rsp_ready[p]) outst[p] = 1'b0;
            fresh[p] = 1'b0;
        end
        if (w >= 0) begin
            outst[w] = 1'b1;
            fresh[w] = 1'b1;
            exp_e[w] = err;
            exp_d[w] = (err || req_write[w]) ? 32'h0 : mmem[idx];
            if (acc && req_write[w])
                for (int b = 0; b < 4; b++)
                    if (req_strb[w][b]) mmem[idx][8*b +: 8] = req_wdata[w][8*b +: 8];
        end
        if (elig == 2'b11) ptr = w;

        @(posedge clk);
        #1;
        if (w >= 0) req_valid[w] = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata0", rsp_rdata[0], 0);
        check("rst_rsp_rdata1", rsp_rdata[1], 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_sram_req", sram_req, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_sram_be", sram_be, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            outst[p] = 1'b0;
            fresh[p] = 1'b0;
        end
        ptr = 1;
    endtask

    task automatic drain();
        rsp_ready = 2'b11;
        for (int k = 0; k < 6 && req_valid != 2'b00; k++) do_cycle();
        do_cycle();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 2'b11;
        mem_seed  = $urandom;
        seed_mem  = 1'b1;
        for (int i = 0; i < 128; i++) mmem[i] = mem_seed ^ (32'(i) * 32'h9E37_79B9);
        @(posedge clk);
        #1;
        seed_mem = 1'b0;

        do_reset();
        do_cycle();

        // Write then cross-port read of the same word.
        issue(0, 1'b1, 32'h0002_0010, 32'hDEAD_BEEF, 4'hF);
        do_cycle();
        check("wr_grant", obs_gnt, 2'b01);
        check("wr_sram_addr", obs_sram_addr, 4);
        check("wr_sram_we", obs_sram_we, 1);
        issue(1, 1'b0, 32'h0002_0010, 32'h0, 4'hF);
        do_cycle();
        check("wr_rsp_valid", obs_valid[0], 1);
        check("wr_rsp_rdata", obs_rdata[0], 0);
        do_cycle();
        check("raw_rdata", obs_rdata[1], 32'hDEAD_BEEF);

        // Both ports streaming reads: strict alternation.
        for (int i = 0; i < 8; i++) begin
            if (!req_valid[0]) issue(0, 1'b0, BASE + 32'(4 * i), 32'h0, 4'hF);
            if (!req_valid[1]) issue(1, 1'b0, BASE + 32'(4 * i + 64), 32'h0, 4'hF);
            do_cycle();
            check("alt_grant", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("alt_sram_req", obs_sram_req, 1);
        end
        drain();

        // Backpressure on port 0 while port 1 streams.
        issue(0, 1'b1, BASE + 32'h4, 32'h1234_5678, 4'hF);
        do_cycle();
        issue(0, 1'b0, BASE + 32'h4, 32'h0, 4'hF);
        do_cycle();
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, BASE + 32'h8, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            if (!req_valid[1]) issue(1, 1'b0, BASE + 32'(4 * (i + 20)), 32'h0, 4'hF);
            do_cycle();
            check("hold_valid", obs_valid[0], 1);
            check("hold_rdata", obs_rdata[0], 32'h1234_5678);
            check("hold_grant", obs_gnt, 2'b10);
        end
        drain();

        // Partial byte write.
        issue(0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
        do_cycle();
        issue(0, 1'b1, BASE + 32'h20, 32'h0000_AB00, 4'h2);
        do_cycle();
        issue(1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
        do_cycle();
        do_cycle();
        check("byte_rdata", obs_rdata[1], 32'hFFFF_ABFF);

        // Reset right after a grant won by port 0 on a tie.
        for (int k = 0; k < 2; k++) begin
            if (!req_valid[0]) issue(0, 1'b0, BASE + 32'h4, 32'h0, 4'hF);
            if (!req_valid[1]) issue(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF);
            do_cycle();
            if (obs_gnt == 2'b01) break;
        end
        do_reset();
        issue(0, 1'b0, BASE + 32'h4, 32'h0, 4'hF);
        issue(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF);
        do_cycle();
        check("post_rst_valid", obs_valid, 0);
        check("post_rst_tie", obs_gnt, 2'b01);
        drain();

`ifdef VWU_DMEM_ARB_ADDR_CHECK_EN
        issue(0, 1'b0, 32'h0002_0200, 32'h0, 4'hF);
        do_cycle();
        check("oob_sram_req", obs_sram_req, 0);
        check("oob_grant", obs_gnt, 2'b01);
        do_cycle();
        check("oob_error", obs_err[0], 1);
        check("oob_rdata", obs_rdata[0], 0);
        issue(0, 1'b0, 32'h0002_01FC, 32'h0, 4'hF);
        do_cycle();
        check("edge_sram_req", obs_sram_req, 1);
        do_cycle();
        check("edge_error", obs_err[0], 0);
`else
        issue(0, 1'b0, 32'h0002_0210, 32'h0, 4'hF);
        do_cycle();
        check("alias_sram_addr", obs_sram_addr, 4);
        do_cycle();
        check("alias_rdata", obs_rdata[0], 32'hDEAD_BEEF);
        check("alias_error", obs_err[0], 0);
`endif

        // Random traffic with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(0, 3) != 0) begin
                    logic [31:0] a;
                    if ($urandom_range(0, 7) == 0) a = $urandom;
                    else a = BASE + (32'($urandom_range(0, 15)) << 2);
                    issue(p, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
                end
            end
            rsp_ready = 2'($urandom);
            do_cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
